uart_loader: RTL and testbench
==============================

# uart_loader

Serial program loader that sits upstream of the CPU core and its 16-entry RAM. It receives a framed program image over a UART RX line and writes it into RAM starting at address 0. It holds the CPU in reset until a complete image with a valid checksum has been stored, then releases it. Its frame format mirrors the uarttx transmitter: 8N1, LSB first, idle high.

## Interface
- WIDTH, 8, data/RAM word width.
- ADDRESS_WIDTH, 4, RAM address width; max image = 2^ADDRESS_WIDTH bytes.
- CLKS_PER_BIT, 104, clk cycles per UART bit; must be ≥ 4 and even.
- clk  input  1  system clock.
- rstn  input  1  reset, synchronous, active-low.
- rx  input  1  asynchronous UART receive line, idle high.
- mem_addr  output  ADDRESS_WIDTH  RAM write address.
- mem_data  output  WIDTH  RAM write data.
- mem_we  output  1  one-cycle RAM write strobe.
- cpu_rstn  output  1  CPU reset, active-low; high only after a successful load.
- busy  output  1  high from the start bit of the length byte until the end of the image.
- err  output  1  one-cycle pulse on a framing, length or checksum error.

## Operation
- rx passes through a 2-flop synchronizer, reset to 1. All decoding uses the synchronized value.
- RX FSM states: R_IDLE, R_START, R_DATA, R_STOP.
  - R_IDLE: on a synchronized 1→0 transition, clear the bit counter and go to R_START.
  - R_START: wait CLKS_PER_BIT/2 cycles, then sample. If 0, go to R_DATA. If 1, treat it as a glitch and return to R_IDLE silently.
  - R_DATA: sample every CLKS_PER_BIT cycles. Shift into the byte LSB first. After 8 samples, go to R_STOP.
  - R_STOP: sample after CLKS_PER_BIT cycles. If 1, raise an internal byte_valid for one cycle. If 0, raise an internal frame_err for one cycle. Either way, return to R_IDLE.
- Loader FSM states: L_LEN, L_DATA, L_SUM, L_DONE.
  - L_LEN, on byte_valid with value N:
    - If 1 ≤ N ≤ 2^ADDRESS_WIDTH: store count = N, clear addr and sum, go to L_DATA.
    - Otherwise: pulse err and stay in L_LEN.
  - L_DATA, on byte_valid with value d:
    - Drive mem_addr = addr and mem_data = d, pulse mem_we.
    - Update sum = (sum + d) mod 2^WIDTH and increment addr.
    - When addr reaches count−1 before the increment, go to L_SUM.
  - L_SUM, on byte_valid with value c:
    - If c == sum: go to L_DONE and set cpu_rstn = 1.
    - Otherwise: pulse err and go to L_LEN. RAM contents are left as written.
  - L_DONE: ignore all rx activity until rstn. cpu_rstn stays 1.
- frame_err in L_LEN, L_DATA or L_SUM pulses err and returns the loader to L_LEN. The partial image stays in RAM, and cpu_rstn stays 0.
- busy = 1 in L_DATA and L_SUM, and in L_LEN while the RX FSM is not in R_IDLE.
- Addresses never wrap, because count ≤ 2^ADDRESS_WIDTH.

## Timing
- Reset values:
  - Outputs: mem_addr 0, mem_data 0, mem_we 0, cpu_rstn 0, busy 0, err 0.
  - Internal: both FSMs in their first state, sync flops 1, sum 0.
- rstn asserted mid-byte or mid-image aborts immediately to the reset state. No further mem_we occurs.
- Synchronizer latency is 2 cycles. The start edge is detected 2–3 cycles after the rx line falls.
- Sample points are nominally at bit centres: start edge + CLKS_PER_BIT/2 + k·CLKS_PER_BIT for k = 0 (start), 1..8 (data), 9 (stop).
- byte_valid and frame_err occur 1 cycle after the stop sample.
- mem_we, mem_addr and mem_data are registered and appear 1 cycle after byte_valid. mem_addr and mem_data hold their values until the next write.
- err follows the same 1-cycle timing.
- cpu_rstn rises 1 cycle after the byte_valid of a correct checksum and never falls again before rstn.
- A new start bit is accepted from the first cycle back in R_IDLE. Back-to-back frames with no idle gap are received correctly.

## Test plan
- Bench uses CLKS_PER_BIT = 16.
- Good image: send 0x03, 0x1E, 0x2F, 0x50, checksum 0x9D.
  - Expect mem_we at addresses 0, 1, 2 with data 0x1E, 0x2F, 0x50.
  - Expect no err, and cpu_rstn rising 1 cycle after the checksum byte.
- Bad checksum: same image with checksum 0x9C.
  - Expect 3 writes, then an err pulse and cpu_rstn still 0.
  - Then resend the image with 0x9D; expect cpu_rstn to go to 1.
- Illegal length: send 0x00, then 0x11.
  - Expect 2 err pulses and no mem_we.
  - Then send 0x01, 0xF0, 0xF0; expect one write (0, 0xF0) and cpu_rstn = 1.
- Framing error: drive the stop bit of the 2nd data byte low.
  - Expect 1 write, then an err pulse and the loader back in L_LEN.
  - Expect no second write and cpu_rstn = 0.
- Glitch and reset:
  - A 5-cycle low pulse on rx: expect no byte and no err.
  - Assert rstn low mid-way through the 2nd data byte: expect all outputs at reset values and no later mem_we.
- Max image: length 0x10 with bytes 0x00..0x0F and checksum 0x78.
  - Expect addresses 0..15 written, no wrap, and cpu_rstn = 1.
  - Further rx traffic after that produces no writes.

Source files
------------

// File: rtl/uart_loader.sv
// UART program loader: receives [len][data x len][checksum] frames (8N1) and writes them to RAM,
// holding the CPU in reset until an image with a matching checksum has been stored.
//
// state   | meaning
// R_IDLE  | waiting for a falling edge on the synchronized rx line
// R_START | half-bit wait, then confirm start bit (high = glitch)
// R_DATA  | sampling data bits LSB first at bit centres
// R_STOP  | sampling the stop bit
// L_LEN   | waiting for the image length byte
// L_DATA  | writing image bytes to RAM
// L_SUM   | waiting for the checksum byte
// L_DONE  | image accepted, CPU released, rx ignored
module uart_loader #(
   parameter int WIDTH         = 8,
   parameter int ADDRESS_WIDTH = 4,
   parameter int CLKS_PER_BIT  = 104
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     rx,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]         mem_data,
   output logic                     mem_we,
   output logic                     cpu_rstn,
   output logic                     busy,
   output logic                     err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(WIDTH);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [31:0] MAX_LEN = 32'(2 ** ADDRESS_WIDTH);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;
   typedef enum logic [1:0] {L_LEN, L_DATA, L_SUM, L_DONE} l_state_t;

   r_state_t r_state_q, r_state_d;
   l_state_t l_state_q, l_state_d;

   logic                     sync1_q, sync2_q, prev_q;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [WIDTH-1:0]         shift_q, shift_d;
   logic                     byte_valid_q, byte_valid_d;
   logic                     frame_err_q, frame_err_d;

   logic [ADDRESS_WIDTH:0]   count_q, count_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]         sum_q, sum_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]         mem_data_q, mem_data_d;
   logic                     mem_we_q, mem_we_d;
   logic                     err_q, err_d;
   logic                     cpu_rstn_q, cpu_rstn_d;
   logic                     len_ok;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         r_state_q    <= R_IDLE;
         cnt_q        <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         byte_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         l_state_q    <= L_LEN;
         count_q      <= '0;
         addr_q       <= '0;
         sum_q        <= '0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
         mem_we_q     <= 1'b0;
         err_q        <= 1'b0;
         cpu_rstn_q   <= 1'b0;
      end else begin
         sync1_q      <= rx;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         r_state_q    <= r_state_d;
         cnt_q        <= cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_valid_q <= byte_valid_d;
         frame_err_q  <= frame_err_d;
         l_state_q    <= l_state_d;
         count_q      <= count_d;
         addr_q       <= addr_d;
         sum_q        <= sum_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
         err_q        <= err_d;
         cpu_rstn_q   <= cpu_rstn_d;
      end
   end

   always_comb begin
      r_state_d    = r_state_q;
      cnt_d        = cnt_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (prev_q && !sync2_q) begin
               cnt_d     = HALF;
               bit_cnt_d = '0;
               r_state_d = R_START;
            end
         end
         R_START: begin
            if (cnt_q == '0) begin
               cnt_d     = FULL;
               r_state_d = sync2_q ? R_IDLE : R_DATA;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         R_DATA: begin
            if (cnt_q == '0) begin
               shift_d   = {sync2_q, shift_q[WIDTH-1:1]};
               bit_cnt_d = bit_cnt_q + BW'(1);
               cnt_d     = FULL;
               if (bit_cnt_q == BW'(WIDTH - 1)) r_state_d = R_STOP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         R_STOP: begin
            if (cnt_q == '0) begin
               byte_valid_d = sync2_q;
               frame_err_d  = !sync2_q;
               r_state_d    = R_IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // shift_q stays stable until the next frame's first data sample, so it is the byte here
   assign len_ok = (shift_q != '0) && (32'(shift_q) <= MAX_LEN);

   always_comb begin
      l_state_d  = l_state_q;
      count_d    = count_q;
      addr_d     = addr_q;
      sum_d      = sum_q;
      mem_addr_d = mem_addr_q;
      mem_data_d = mem_data_q;
      mem_we_d   = 1'b0;
      err_d      = 1'b0;
      cpu_rstn_d = cpu_rstn_q;
      if (frame_err_q && l_state_q != L_DONE) begin
         err_d     = 1'b1;
         l_state_d = L_LEN;
      end else if (byte_valid_q) begin
         case (l_state_q)
            L_LEN: begin
               if (len_ok) begin
                  count_d   = (ADDRESS_WIDTH + 1)'(shift_q);
                  addr_d    = '0;
                  sum_d     = '0;
                  l_state_d = L_DATA;
               end else begin
                  err_d = 1'b1;
               end
            end
            L_DATA: begin
               mem_addr_d = addr_q;
               mem_data_d = shift_q;
               mem_we_d   = 1'b1;
               sum_d      = sum_q + shift_q;
               addr_d     = addr_q + ADDRESS_WIDTH'(1);
               if ({1'b0, addr_q} == count_q - (ADDRESS_WIDTH + 1)'(1)) l_state_d = L_SUM;
            end
            L_SUM: begin
               if (shift_q == sum_q) begin
                  cpu_rstn_d = 1'b1;
                  l_state_d  = L_DONE;
               end else begin
                  err_d     = 1'b1;
                  l_state_d = L_LEN;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_data = mem_data_q;
   assign mem_we   = mem_we_q;
   assign err      = err_q;
   assign cpu_rstn = cpu_rstn_q;
   assign busy     = (l_state_q == L_DATA) || (l_state_q == L_SUM) ||
                     ((l_state_q == L_LEN) && (r_state_q != R_IDLE));

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: directed and random images, expected RAM writes / err / cpu release
// events queued by a reference model and checked by an independent monitor.
module tb_uart_loader;
   localparam int CPB = 16;
   localparam int AW  = 4;
   localparam int W   = 8;
   localparam int LAT = 156;  // cycles from start-bit drive to registered output event

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          rx = 1'b1;
   logic [AW-1:0] mem_addr;
   logic [W-1:0]  mem_data;
   logic          mem_we, cpu_rstn, busy, err;

   uart_loader #(.WIDTH(W), .ADDRESS_WIDTH(AW), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rstn(rstn), .rx(rx), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_we(mem_we), .cpu_rstn(cpu_rstn), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   longint cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int kind; int addr; int data; longint due;} ev_t;  // kind 0 write, 1 err, 2 release
   ev_t exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   int         m_mode;  // 0 length, 1 data, 2 checksum, 3 released
   int         m_len;
   logic [7:0] m_img[$];
   logic [7:0] tx_q[$];

   function automatic void model_reset();
      m_mode = 0;
      m_len  = 0;
      m_img.delete();
   endfunction

   function automatic void push_ev(int k, int a, int d, longint due);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d; e.due = due;
      exp_q.push_back(e);
   endfunction

   function automatic void model_byte(input logic [7:0] b, input bit ok, input longint due);
      int s;
      if (m_mode == 3) return;
      if (!ok) begin
         push_ev(1, 0, 0, due);
         m_mode = 0;
         return;
      end
      case (m_mode)
         0: if (b >= 1 && b <= 16) begin
               m_len = int'(b);
               m_img.delete();
               m_mode = 1;
            end else push_ev(1, 0, 0, due);
         1: begin
               push_ev(0, m_img.size(), int'(b), due);
               m_img.push_back(b);
               if (m_img.size() == m_len) m_mode = 2;
            end
         default: begin
               s = 0;
               foreach (m_img[i]) s += int'(m_img[i]);
               if (int'(b) == s % 256) begin
                  push_ev(2, 0, 0, due);
                  m_mode = 3;
               end else begin
                  push_ev(1, 0, 0, due);
                  m_mode = 0;
               end
            end
      endcase
   endfunction

   function automatic void mon_pop(int k, int a, int d);
      ev_t e;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL unexpected_event: got kind=%0d addr=%0h data=%0h at cyc %0d, expected none", k, a, d, cyc);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.addr != a || e.data != d || cyc < e.due - 2 || cyc > e.due + 2) begin
            n_err++;
            $display("FAIL event: got kind=%0d addr=%0h data=%0h cyc=%0d, expected kind=%0d addr=%0h data=%0h cyc=%0d",
                     k, a, d, cyc, e.kind, e.addr, e.data, e.due);
         end
      end
   endfunction

   logic prev_cpu = 1'b0;
   always @(negedge clk) begin
      if (!rstn) begin
         prev_cpu <= 1'b0;
      end else begin
         if (mem_we) mon_pop(0, int'(mem_addr), int'(mem_data));
         if (err) mon_pop(1, 0, 0);
         if (cpu_rstn && !prev_cpu) mon_pop(2, 0, 0);
         if (!cpu_rstn && prev_cpu) begin
            n_cmp++;
            n_err++;
            $display("FAIL cpu_rstn_fell: got 0 expected 1 at cyc %0d", cyc);
         end
         prev_cpu <= cpu_rstn;
      end
   end

   task automatic check(input string nm, input longint act, input longint expv);
      n_cmp++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit stop_ok);
      longint c0;
      c0 = cyc;
      model_byte(b, stop_ok, c0 + LAT);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(CPB);
      end
      rx = stop_ok;
      idle(CPB);
      rx = 1'b1;
      if (!stop_ok) idle(CPB);
   endtask

   task automatic send_list(input bit gaps);
      foreach (tx_q[i]) begin
         send_byte(tx_q[i], 1'b1);
         if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 20));
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      rx   = 1'b1;
      idle(3);
      exp_q.delete();
      model_reset();
      rstn = 1'b1;
      idle(2);
   endtask

   task automatic check_reset_outputs(input string nm);
      check({nm, "_mem_addr"}, longint'(mem_addr), 0);
      check({nm, "_mem_data"}, longint'(mem_data), 0);
      check({nm, "_mem_we"}, longint'(mem_we), 0);
      check({nm, "_cpu_rstn"}, longint'(cpu_rstn), 0);
      check({nm, "_busy"}, longint'(busy), 0);
      check({nm, "_err"}, longint'(err), 0);
   endtask

   task automatic end_check(input string nm, input bit exp_cpu);
      idle(8);
      check({nm, "_pending"}, longint'(exp_q.size()), 0);
      check({nm, "_cpu_rstn"}, longint'(cpu_rstn), longint'(exp_cpu));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at cyc %0d, expected finish", cyc);
      $fatal(1);
   end

   initial begin
      int len, s;
      logic [7:0] b;
      model_reset();
      idle(3);
      check_reset_outputs("reset_held");
      rstn = 1'b1;
      idle(2);
      check_reset_outputs("reset_released");

      // good image
      send_byte(8'h03, 1'b1);
      check("good_busy_in_data", longint'(busy), 1);
      tx_q = '{8'h1E, 8'h2F, 8'h50, 8'h9D};
      send_list(1'b0);
      end_check("good", 1'b1);
      check("good_busy_done", longint'(busy), 0);
      check("good_last_addr", longint'(mem_addr), 2);
      check("good_last_data", longint'(mem_data), 8'h50);

      // bad checksum then retry
      do_reset();
      tx_q = '{8'h03, 8'h1E, 8'h2F, 8'h50, 8'h9C};
      send_list(1'b0);
      end_check("badsum", 1'b0);
      tx_q = '{8'h03, 8'h1E, 8'h2F, 8'h50, 8'h9D};
      send_list(1'b0);
      end_check("badsum_retry", 1'b1);

      // illegal lengths then a one-byte image
      do_reset();
      tx_q = '{8'h00, 8'h11};
      send_list(1'b0);
      end_check("badlen", 1'b0);
      tx_q = '{8'h01, 8'hF0, 8'hF0};
      send_list(1'b0);
      end_check("len1", 1'b1);
      check("len1_addr", longint'(mem_addr), 0);
      check("len1_data", longint'(mem_data), 8'hF0);

      // framing error on the second data byte, then a recovery image
      do_reset();
      send_byte(8'h03, 1'b1);
      send_byte(8'h1E, 1'b1);
      send_byte(8'h2F, 1'b0);
      end_check("frame", 1'b0);
      check("frame_busy", longint'(busy), 0);
      tx_q = '{8'h01, 8'hAA, 8'hAA};
      send_list(1'b0);
      end_check("frame_recover", 1'b1);

      // glitch, then reset mid-way through the second data byte
      do_reset();
      rx = 1'b0;
      idle(5);
      rx = 1'b1;
      idle(200);
      end_check("glitch", 1'b0);
      tx_q = '{8'h03, 8'h1E};
      send_list(1'b0);
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = 1'($urandom_range(0, 1));
         idle(CPB);
      end
      rstn = 1'b0;
      idle(2);
      check_reset_outputs("midbyte_reset");
      exp_q.delete();
      model_reset();
      rx = 1'b1;
      idle(2);
      rstn = 1'b1;
      idle(400);
      end_check("after_reset", 1'b0);
      check("after_reset_we", longint'(mem_we), 0);

      // maximum image, then traffic that must be ignored
      do_reset();
      tx_q.delete();
      tx_q.push_back(8'h10);
      for (int i = 0; i < 16; i++) tx_q.push_back(8'(i));
      tx_q.push_back(8'h78);
      send_list(1'b0);
      end_check("max", 1'b1);
      check("max_last_addr", longint'(mem_addr), 15);
      tx_q = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
      send_list(1'b0);
      end_check("max_after", 1'b1);
      check("max_after_addr", longint'(mem_addr), 15);

      // random images
      for (int t = 0; t < 8; t++) begin
         do_reset();
         tx_q.delete();
         if ($urandom_range(0, 3) == 0)
            tx_q.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(17, 255)));
         len = $urandom_range(1, 16);
         tx_q.push_back(8'(len));
         s = 0;
         for (int i = 0; i < len; i++) begin
            b = 8'($urandom_range(0, 255));
            s += int'(b);
            tx_q.push_back(b);
         end
         b = 8'(s % 256);
         if ($urandom_range(0, 1) == 0) b = b ^ 8'($urandom_range(1, 255));
         tx_q.push_back(b);
         send_list(1'b1);
         end_check($sformatf("rand%0d", t), m_mode == 3);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
